// File: rtl/onehot_reducer_if.sv
// Handshake bundle for the one-hot reducer.
// Master drives load/clear; slave returns the working vector and status.
interface onehot_reducer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             clear;
   logic [WIDTH-1:0] vec_out;
   logic             vec_valid;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] steps;

   modport master (
      output start, din, clear,
      input  vec_out, vec_valid, busy, done, err, steps
   );

   modport slave (
      input  start, din, clear,
      output vec_out, vec_valid, busy, done, err, steps
   );
endinterface

// File: rtl/onehot_reducer.sv
// Loads a nonzero vector and clears its lowest set bit each cycle
// until only the original MSB remains; counts the clears.
module onehot_reducer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input logic clk,
   input logic rst,
   onehot_reducer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   state_t           state, state_n;
   logic [WIDTH-1:0] vec_q, vec_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [WIDTH-1:0] vec_lo;
   logic             is_onehot;

   // Lowest-set-bit clear and exactly-one-bit test on the working vector
   always_comb begin
      vec_lo    = vec_q & (vec_q - ONE);
      is_onehot = (vec_q != '0) && (vec_lo == '0);
   end

   // State and working registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vec_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_n;
         vec_q <= vec_n;
         cnt_q <= cnt_n;
      end
   end

   // Next state: load from IDLE/DONE/ERR, reduce while in RUN
   always_comb begin
      state_n = state;
      vec_n   = vec_q;
      cnt_n   = cnt_q;
      unique case (state)
         RUN: begin
            if (is_onehot) begin
               state_n = DONE;
            end else begin
               vec_n = vec_lo;
               if (cnt_q != CMAX) cnt_n = cnt_q + 1'b1;
            end
         end
         IDLE, DONE, ERR: begin
            if (bus.start) begin
               cnt_n = '0;
               if (bus.din != '0) begin
                  state_n = RUN;
                  vec_n   = bus.din;
               end else begin
                  state_n = ERR;
                  vec_n   = '0;
               end
            end else if (bus.clear && state != IDLE) begin
               state_n = IDLE;
               vec_n   = '0;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Status outputs decoded from the registered state
   always_comb begin
      bus.vec_out   = vec_q;
      bus.steps     = cnt_q;
      bus.busy      = (state == RUN);
      bus.done      = (state == DONE);
      bus.err       = (state == ERR);
      bus.vec_valid = (state == RUN) || (state == DONE);
   end
endmodule

// File: tb/tb_onehot_reducer.sv
// Bench for onehot_reducer: vector table, corner sequences and
// random loads checked against a bit-clearing reference model.
module tb_onehot_reducer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   onehot_reducer_if #(.WIDTH(4), .CNT_W(3)) bus ();

   onehot_reducer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] din;
      logic [3:0] fin;
      int         stp;
   } vec_t;

   vec_t tbl[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_vec"}, 32'(bus.vec_out), 0);
      chk({nm, "_val"}, 32'(bus.vec_valid), 0);
      chk({nm, "_busy"}, 32'(bus.busy), 0);
      chk({nm, "_done"}, 32'(bus.done), 0);
      chk({nm, "_err"}, 32'(bus.err), 0);
      chk({nm, "_steps"}, 32'(bus.steps), 0);
   endtask

   // Model: strip set bits from the bottom until one remains
   task automatic do_run(input logic [3:0] d, input logic clr);
      logic [3:0] q[$];
      logic [3:0] v;
      int         n;
      v = d;
      q.push_back(v);
      for (int i = 0; i < 4; i++) begin
         if (v[i] && $countones(v) > 1) begin
            v[i] = 1'b0;
            q.push_back(v);
         end
      end
      bus.start = 1'b1;
      bus.din   = d;
      bus.clear = clr;
      step();
      bus.start = 1'b0;
      bus.clear = 1'b0;
      bus.din   = 4'($urandom);
      if (d == 4'd0) begin
         chk("err_flag", 32'(bus.err), 1);
         chk("err_val", 32'(bus.vec_valid), 0);
         chk("err_done", 32'(bus.done), 0);
         chk("err_busy", 32'(bus.busy), 0);
         chk("err_vec", 32'(bus.vec_out), 0);
         return;
      end
      n = q.size();
      for (int k = 0; k < n; k++) begin
         chk("run_vec", 32'(bus.vec_out), 32'(q[k]));
         chk("run_busy", 32'(bus.busy), 1);
         chk("run_done", 32'(bus.done), 0);
         chk("run_valid", 32'(bus.vec_valid), 1);
         chk("run_steps", 32'(bus.steps), 32'(k));
         chk("run_fin", 32'($onehot(bus.vec_out)), 32'(k == n - 1));
         step();
      end
      chk("fin_done", 32'(bus.done), 1);
      chk("fin_busy", 32'(bus.busy), 0);
      chk("fin_valid", 32'(bus.vec_valid), 1);
      chk("fin_err", 32'(bus.err), 0);
      chk("fin_vec", 32'(bus.vec_out), 32'(q[n-1]));
      chk("fin_steps", 32'(bus.steps), 32'(n - 1));
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      chk_idle("clr");
   endtask

   initial begin
      tbl[0] = '{4'b1011, 4'b1000, 2};
      tbl[1] = '{4'b0100, 4'b0100, 0};
      tbl[2] = '{4'b1111, 4'b1000, 3};
      tbl[3] = '{4'b0011, 4'b0010, 1};
      tbl[4] = '{4'b0110, 4'b0100, 1};
      tbl[5] = '{4'b0001, 4'b0001, 0};
      tbl[6] = '{4'b1001, 4'b1000, 1};

      bus.start = 1'b0;
      bus.din   = '0;
      bus.clear = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk_idle("rst");

      for (int t = 0; t < 7; t++) begin
         do_run(tbl[t].din, 1'b0);
         chk("tbl_fin", 32'(bus.vec_out), 32'(tbl[t].fin));
         chk("tbl_steps", 32'(bus.steps), 32'(tbl[t].stp));
         do_clear();
      end

      // start beats clear from DONE
      do_run(4'b1111, 1'b0);
      do_run(4'b0011, 1'b1);
      chk("restart_fin", 32'(bus.vec_out), 32'h2);

      // zero load then clear
      do_clear();
      do_run(4'b0000, 1'b0);
      do_clear();

      // reset in the middle of a reduction
      bus.start = 1'b1;
      bus.din   = 4'b1110;
      step();
      bus.start = 1'b0;
      step();
      chk("mid_vec", 32'(bus.vec_out), 32'hC);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("midrst");
      do_run(4'b0110, 1'b0);
      chk("post_rst_fin", 32'(bus.vec_out), 32'h4);
      do_clear();

      // start/clear ignored while reducing
      bus.start = 1'b1;
      bus.din   = 4'b1101;
      step();
      bus.din   = 4'b0001;
      bus.clear = 1'b1;
      step();
      bus.start = 1'b0;
      bus.clear = 1'b0;
      chk("ign_vec1", 32'(bus.vec_out), 32'hC);
      chk("ign_busy", 32'(bus.busy), 1);
      step();
      chk("ign_vec2", 32'(bus.vec_out), 32'h8);
      step();
      chk("ign_done", 32'(bus.done), 1);
      chk("ign_steps", 32'(bus.steps), 2);
      chk("ign_vec3", 32'(bus.vec_out), 32'h8);

      // random loads, sometimes cleared, sometimes restarted directly
      for (int r = 0; r < 60; r++) begin
         do_run(4'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) do_clear();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/onehot_reducer.md
Name: onehot_reducer

Overview:
- Sequential source of one-hot 4-bit vectors for the one-hot completion checker.
- Loads an arbitrary nonzero vector and, once per clock, clears its lowest set bit until exactly one bit remains (the original MSB set).
- Presents every intermediate vector on vec_out so the downstream one-hot checker can watch it and raise its finished flag on the final value.
- Also reports the number of reduction steps and flags an all-zero load as an error.

Parameters:
- WIDTH, 4: vector width; must match the checker width.
- CNT_W, 3: width of the step counter; must hold WIDTH-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE, DONE and ERR.
- din  input  WIDTH  vector captured on an accepted start.
- clear  input  1  returns DONE or ERR to IDLE.
- vec_out  output  WIDTH  current working vector.
- vec_valid  output  1  vec_out holds a loaded or reduced vector.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; vec_out is one-hot.
- err  output  1  high in ERR; an all-zero vector was loaded.
- steps  output  CNT_W  count of bit-clear operations performed on the current vector.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - rst=1 at an edge forces IDLE, vec_out=0, vec_valid=0, busy=0, done=0, err=0, steps=0.
  - Reset overrides everything, including mid-RUN; there is no asynchronous path.
- States: IDLE, RUN, DONE, ERR. All outputs are registered and decoded from state and working registers.
- IDLE:
  - start=1 with din!=0 -> RUN; vec_out<=din; steps<=0; vec_valid<=1.
  - start=1 with din==0 -> ERR; vec_out<=0; vec_valid<=0.
  - start=0 -> stay; outputs unchanged.
- RUN, evaluated each edge on the registered vec_out:
  - If vec_out has exactly one bit set -> DONE; vec_out and steps hold.
  - Otherwise vec_out <= vec_out & (vec_out - 1), computed with WIDTH-bit arithmetic and wrap discarded; steps <= steps + 1.
  - start and clear are ignored while in RUN.
- One-hot test: exactly one bit set. Zero and multi-bit vectors are not one-hot. This matches the checker's is_finished on the same vector.
- Latency:
  - With P = popcount(din), vec_out shows din one edge after start is accepted.
  - vec_out becomes one-hot P-1 edges later.
  - done rises one edge after that, i.e. P+1 edges after start is sampled.
  - Final steps = P-1. A din that is already one-hot gives done 2 edges after start, with steps=0.
- DONE:
  - Outputs hold (done=1, vec_valid=1, busy=0) until an accepted start or clear.
  - start=1 takes priority over clear: the new din is loaded as in IDLE.
  - clear=1 alone -> IDLE with vec_out=0, vec_valid=0, steps=0.
- ERR: err=1 held. start and clear are handled exactly as in DONE.
- steps saturates at 2^CNT_W-1. This is unreachable when CNT_W is sized per its parameter note.
- Final vec_out equals the MSB set in din; no other bit survives.

Test Plan:
- Reset then start with din=4'b1011 -> vec_out sequence 1011, 1010, 1000; done=1 on the 4th edge after start; steps=2; busy high for exactly 3 cycles; checker is_finished=1 only on 1000.
- start with din=4'b0100 -> vec_out=0100 after edge 1; done=1 after edge 2; steps=0; busy high for exactly 1 cycle.
- start with din=4'b1111 -> vec_out 1111, 1110, 1100, 1000; done after edge 5; steps=3. Then start=1 and clear=1 together with din=0011 -> restart; vec_out 0011, 0010; done; steps=1.
- start with din=0 -> err=1 after edge 1, vec_valid=0, done=0. Then clear=1 -> IDLE with all outputs 0.
- Assert rst for one edge while in RUN with din=1110 after the first reduction -> next state IDLE, all outputs 0. A following start with din=0110 runs normally to 0100 with steps=1.
- In RUN, pulse start with din=0001 and clear=1 -> both ignored; the original reduction completes unchanged.
